// File: rtl/espirometro_session_ctrl_pkg.sv
// Shared state encoding for the spirometer session controller and its display/VGA consumers.
package espirometro_session_ctrl_pkg;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_MEASURE = 3'd2,
        ST_RESULT  = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;
endpackage

// File: rtl/espirometro_session_ctrl_acumulador_sat.sv
// Saturating volume accumulator: clear wins over enable, sum clamps at all-ones.
module acumulador_sat #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 14
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iClr,
    input  logic             iEn,
    input  logic [IN_W-1:0]  ivDato,
    output logic [ACC_W-1:0] ovAcc
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    // One extra bit catches the carry that signals saturation.
    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(ivDato);

    always_ff @(posedge iClk) begin
        if (iReset)
            r_acc <= '0;
        else if (iClr)
            r_acc <= '0;
        else if (iEn)
            r_acc <= w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    end

    assign ovAcc = r_acc;
endmodule

// File: rtl/espirometro_session_ctrl.sv
// Forced-exhalation test sequencer: arm, wait for blow, integrate volume, end on low flow or budget.
module espirometro_session_ctrl
    import espirometro_session_ctrl_pkg::*;
#(
    parameter int SAMPLE_W     = 8,
    parameter int VOL_W        = 14,
    parameter int START_TH     = 20,
    parameter int STOP_TH      = 10,
    parameter int STOP_CNT     = 4,
    parameter int WAIT_TIMEOUT = 40,
    parameter int MAX_SAMPLES  = 80
) (
    input  logic                iClk,
    input  logic                iReset,
    input  logic                iStart,
    input  logic                iSampleTick,
    input  logic [SAMPLE_W-1:0] ivDatos,
    output logic [STATE_W-1:0]  ovState,
    output logic [VOL_W-1:0]    ovVolumen,
    output logic [SAMPLE_W-1:0] ovPico,
    output logic [7:0]          ovMuestras,
    output logic                oMedir,
    output logic                oDone,
    output logic                oLoser
);
    state_t              r_state, w_next;
    logic [SAMPLE_W-1:0] r_pico;
    logic [7:0]          r_muestras, r_low, r_tmo;
    logic                r_medir, r_done, r_loser;
    logic                w_clr, w_acc, w_tmo_inc;
    logic [7:0]          w_low_nx, w_mues_nx;

    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_acc     = 1'b0;
        w_tmo_inc = 1'b0;
        w_low_nx  = (ivDatos < SAMPLE_W'(STOP_TH)) ? r_low + 8'd1 : 8'd0;
        w_mues_nx = r_muestras + 8'd1;
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_next = ST_WAIT;
                    w_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                // A coincident start aborts and the sample is dropped.
                if (iStart) begin
                    w_next = ST_IDLE;
                    w_clr  = 1'b1;
                end else if (iSampleTick) begin
                    if (ivDatos >= SAMPLE_W'(START_TH)) begin
                        w_next = ST_MEASURE;
                        w_acc  = 1'b1;
                    end else begin
                        w_tmo_inc = 1'b1;
                        if (r_tmo + 8'd1 == 8'(WAIT_TIMEOUT))
                            w_next = ST_FAIL;
                    end
                end
            end
            ST_MEASURE: begin
                if (iStart) begin
                    w_next = ST_IDLE;
                    w_clr  = 1'b1;
                end else if (iSampleTick) begin
                    w_acc = 1'b1;
                    if (w_low_nx == 8'(STOP_CNT) || w_mues_nx == 8'(MAX_SAMPLES))
                        w_next = ST_RESULT;
                end
            end
            ST_RESULT, ST_FAIL: begin
                if (iStart) begin
                    w_next = ST_WAIT;
                    w_clr  = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
                w_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state    <= ST_IDLE;
            r_pico     <= '0;
            r_muestras <= '0;
            r_low      <= '0;
            r_tmo      <= '0;
            r_medir    <= 1'b0;
            r_done     <= 1'b0;
            r_loser    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_pico     <= '0;
                r_muestras <= '0;
                r_low      <= '0;
                r_tmo      <= '0;
            end else if (w_acc) begin
                r_pico     <= (ivDatos > r_pico) ? ivDatos : r_pico;
                r_muestras <= w_mues_nx;
                // The entry sample is above the start threshold, so the low run starts empty.
                r_low      <= (r_state == ST_MEASURE) ? w_low_nx : 8'd0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + 8'd1;
            end
            r_medir <= (w_next == ST_MEASURE);
            r_done  <= (w_next == ST_RESULT) && (r_state != ST_RESULT);
            r_loser <= (w_next == ST_FAIL);
        end
    end

    acumulador_sat #(
        .IN_W  (SAMPLE_W),
        .ACC_W (VOL_W)
    ) u_acc (
        .iClk   (iClk),
        .iReset (iReset),
        .iClr   (w_clr),
        .iEn    (w_acc),
        .ivDato (ivDatos),
        .ovAcc  (ovVolumen)
    );

    assign ovState    = r_state;
    assign ovPico     = r_pico;
    assign ovMuestras = r_muestras;
    assign oMedir     = r_medir;
    assign oDone      = r_done;
    assign oLoser     = r_loser;
endmodule

// File: tb/tb_espirometro_session_ctrl.sv
// Directed bench for the spirometer session controller: vector table plus multi-cycle sequences.
module tb_espirometro_session_ctrl;
    logic        iClk = 1'b0;
    logic        iReset, iStart, iSampleTick;
    logic [7:0]  ivDatos;
    logic [2:0]  ovState;
    logic [13:0] ovVolumen;
    logic [7:0]  ovPico, ovMuestras;
    logic        oMedir, oDone, oLoser;

    int checks = 0;
    int errors = 0;

    espirometro_session_ctrl dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iStart      (iStart),
        .iSampleTick (iSampleTick),
        .ivDatos     (ivDatos),
        .ovState     (ovState),
        .ovVolumen   (ovVolumen),
        .ovPico      (ovPico),
        .ovMuestras  (ovMuestras),
        .oMedir      (oMedir),
        .oDone       (oDone),
        .oLoser      (oLoser)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic        st;
        logic        tk;
        logic [7:0]  d;
        logic [2:0]  s;
        logic [13:0] v;
        logic [7:0]  p;
        logic [7:0]  m;
        logic        med;
        logic        dn;
        logic        lo;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, input logic tk, input int d, input int s, input int v,
                       input int p, input int m, input logic med, input logic dn, input logic lo);
        vec_t x;
        x.st = st; x.tk = tk; x.d = 8'(d); x.s = 3'(s); x.v = 14'(v);
        x.p = 8'(p); x.m = 8'(m); x.med = med; x.dn = dn; x.lo = lo;
        vq.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic tk, input int d);
        iStart = st; iSampleTick = tk; ivDatos = 8'(d);
        @(posedge iClk); #1;
        iStart = 1'b0; iSampleTick = 1'b0; ivDatos = 8'd0;
    endtask

    task automatic chk_all(input string tag, input int s, input int v, input int p, input int m,
                           input int med, input int dn, input int lo);
        chk({tag, ".state"}, int'(ovState), s);
        chk({tag, ".vol"},   int'(ovVolumen), v);
        chk({tag, ".pico"},  int'(ovPico), p);
        chk({tag, ".mues"},  int'(ovMuestras), m);
        chk({tag, ".medir"}, int'(oMedir), med);
        chk({tag, ".done"},  int'(oDone), dn);
        chk({tag, ".loser"}, int'(oLoser), lo);
    endtask

    initial begin
        // Nominal run
        add(1,0, 0, 1,  0, 0,0, 0,0,0);
        add(0,1, 5, 1,  0, 0,0, 0,0,0);
        add(0,1,30, 2, 30,30,1, 1,0,0);
        add(0,1,50, 2, 80,50,2, 1,0,0);
        add(0,1,40, 2,120,50,3, 1,0,0);
        add(0,1, 8, 2,128,50,4, 1,0,0);
        add(0,1, 8, 2,136,50,5, 1,0,0);
        add(0,1, 8, 2,144,50,6, 1,0,0);
        add(0,1, 8, 3,152,50,7, 0,1,0);
        add(0,0, 0, 3,152,50,7, 0,0,0);
        add(0,1,99, 3,152,50,7, 0,0,0);
        // Low run interrupted by a high sample
        add(1,0, 0, 1,  0, 0,0, 0,0,0);
        add(0,1,30, 2, 30,30,1, 1,0,0);
        add(0,1, 5, 2, 35,30,2, 1,0,0);
        add(0,1, 5, 2, 40,30,3, 1,0,0);
        add(0,1, 5, 2, 45,30,4, 1,0,0);
        add(0,1,25, 2, 70,30,5, 1,0,0);
        add(0,1, 5, 2, 75,30,6, 1,0,0);
        add(0,1, 5, 2, 80,30,7, 1,0,0);
        add(0,1, 5, 2, 85,30,8, 1,0,0);
        add(0,1, 5, 3, 90,30,9, 0,1,0);
        // Abort with coincident tick, then back-to-back start pulses
        add(1,0, 0, 1,  0, 0,0, 0,0,0);
        add(0,1,30, 2, 30,30,1, 1,0,0);
        add(0,1,60, 2, 90,60,2, 1,0,0);
        add(1,1,90, 0,  0, 0,0, 0,0,0);
        add(1,0, 0, 1,  0, 0,0, 0,0,0);
        add(1,0, 0, 0,  0, 0,0, 0,0,0);

        iReset = 1'b1; iStart = 1'b0; iSampleTick = 1'b0; ivDatos = 8'd0;
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].st, vq[i].tk, int'(vq[i].d));
            chk_all($sformatf("vec%0d", i), vq[i].s, vq[i].v, vq[i].p, vq[i].m,
                    vq[i].med, vq[i].dn, vq[i].lo);
        end

        // No-blow timeout
        drive(1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            drive(0, 1, 0);
            chk($sformatf("tmo%0d.state", k), int'(ovState), (k == 40) ? 4 : 1);
        end
        chk_all("fail", 4, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 200);
        chk("fail_tick.state", int'(ovState), 4);
        drive(1, 0, 0);
        chk_all("fail_restart", 1, 0, 0, 0, 0, 0, 0);

        // Sample budget with saturation
        for (int k = 1; k <= 80; k++) begin
            int ev;
            drive(0, 1, 255);
            ev = (255 * k > 16383) ? 16383 : 255 * k;
            chk($sformatf("sat%0d.vol", k), int'(ovVolumen), ev);
            chk($sformatf("sat%0d.state", k), int'(ovState), (k == 80) ? 3 : 2);
        end
        chk_all("budget", 3, 16383, 255, 80, 0, 1, 0);

        // Reset beats a coincident start and tick
        drive(1, 0, 0);
        drive(0, 1, 100);
        chk_all("pre_rst", 2, 100, 100, 1, 1, 0, 0);
        iReset = 1'b1;
        drive(1, 1, 50);
        iReset = 1'b0;
        chk_all("rst_prio", 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
